// File: rtl/ysyx_25030093_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter.
// One transaction in flight; grant held from address phase to final response.
module ysyx_25030093_axi_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter bit          LSU_PRIORITY = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  // IFU read
  input  logic            ifu_arvalid,
  input  logic [AW-1:0]   ifu_araddr,
  input  logic [3:0]      ifu_arid,
  input  logic [7:0]      ifu_arlen,
  input  logic [2:0]      ifu_arsize,
  input  logic [1:0]      ifu_arburst,
  output logic            ifu_arready,
  output logic            ifu_rvalid,
  output logic [DW-1:0]   ifu_rdata,
  output logic [1:0]      ifu_rresp,
  output logic            ifu_rlast,
  output logic [3:0]      ifu_rid,
  input  logic            ifu_rready,
  // LSU read
  input  logic            lsu_arvalid,
  input  logic [AW-1:0]   lsu_araddr,
  input  logic [3:0]      lsu_arid,
  input  logic [7:0]      lsu_arlen,
  input  logic [2:0]      lsu_arsize,
  input  logic [1:0]      lsu_arburst,
  output logic            lsu_arready,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   lsu_rdata,
  output logic [1:0]      lsu_rresp,
  output logic            lsu_rlast,
  output logic [3:0]      lsu_rid,
  input  logic            lsu_rready,
  // LSU write
  input  logic            lsu_awvalid,
  input  logic [AW-1:0]   lsu_awaddr,
  input  logic [3:0]      lsu_awid,
  input  logic [7:0]      lsu_awlen,
  input  logic [2:0]      lsu_awsize,
  input  logic [1:0]      lsu_awburst,
  output logic            lsu_awready,
  input  logic            lsu_wvalid,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  input  logic            lsu_wlast,
  output logic            lsu_wready,
  output logic            lsu_bvalid,
  output logic [1:0]      lsu_bresp,
  output logic [3:0]      lsu_bid,
  input  logic            lsu_bready,
  // Slave-side master port
  output logic            m_arvalid,
  output logic [AW-1:0]   m_araddr,
  output logic [3:0]      m_arid,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  input  logic            m_arready,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic [3:0]      m_rid,
  output logic            m_rready,
  output logic            m_awvalid,
  output logic [AW-1:0]   m_awaddr,
  output logic [3:0]      m_awid,
  output logic [7:0]      m_awlen,
  output logic [2:0]      m_awsize,
  output logic [1:0]      m_awburst,
  input  logic            m_awready,
  output logic            m_wvalid,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  output logic            m_wlast,
  input  logic            m_wready,
  input  logic            m_bvalid,
  input  logic [1:0]      m_bresp,
  input  logic [3:0]      m_bid,
  output logic            m_bready
);

  typedef enum logic [1:0] {IDLE, RD_IFU, RD_LSU, WR_LSU} state_e;

  state_e state_q, state_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   lsu_last_q, lsu_last_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ar_done_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      lsu_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_done_q  <= ar_done_d;
      aw_done_q  <= aw_done_d;
      lsu_last_q <= lsu_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lsu_last_d  = lsu_last_q;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rlast   = 1'b0;
    ifu_rid     = '0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rlast   = 1'b0;
    lsu_rid     = '0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = '0;
    lsu_bid     = '0;
    m_arvalid   = 1'b0;
    m_araddr    = '0;
    m_arid      = '0;
    m_arlen     = '0;
    m_arsize    = '0;
    m_arburst   = '0;
    m_rready    = 1'b0;
    m_awvalid   = 1'b0;
    m_awaddr    = '0;
    m_awid      = '0;
    m_awlen     = '0;
    m_awsize    = '0;
    m_awburst   = '0;
    m_wvalid    = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wlast     = 1'b0;
    m_bready    = 1'b0;

    case (state_q)
      IDLE: begin
        // Round-robin only breaks a simultaneous read tie; writes always go first.
        if (lsu_awvalid || lsu_wvalid)        state_d = WR_LSU;
        else if (lsu_arvalid && ifu_arvalid)  state_d = (LSU_PRIORITY || !lsu_last_q) ? RD_LSU : RD_IFU;
        else if (lsu_arvalid)                 state_d = RD_LSU;
        else if (ifu_arvalid)                 state_d = RD_IFU;
        if (state_d != IDLE) lsu_last_d = (state_d != RD_IFU);
      end
      RD_IFU: begin
        m_arvalid   = ifu_arvalid & ~ar_done_q;
        m_araddr    = ifu_araddr;
        m_arid      = ifu_arid;
        m_arlen     = ifu_arlen;
        m_arsize    = ifu_arsize;
        m_arburst   = ifu_arburst;
        ifu_arready = m_arready & ~ar_done_q;
        ifu_rvalid  = m_rvalid;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rlast   = m_rlast;
        ifu_rid     = m_rid;
        m_rready    = ifu_rready;
        if (m_rvalid && m_rready && m_rlast) state_d = IDLE;
      end
      RD_LSU: begin
        m_arvalid   = lsu_arvalid & ~ar_done_q;
        m_araddr    = lsu_araddr;
        m_arid      = lsu_arid;
        m_arlen     = lsu_arlen;
        m_arsize    = lsu_arsize;
        m_arburst   = lsu_arburst;
        lsu_arready = m_arready & ~ar_done_q;
        lsu_rvalid  = m_rvalid;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rlast   = m_rlast;
        lsu_rid     = m_rid;
        m_rready    = lsu_rready;
        if (m_rvalid && m_rready && m_rlast) state_d = IDLE;
      end
      WR_LSU: begin
        m_awvalid   = lsu_awvalid & ~aw_done_q;
        m_awaddr    = lsu_awaddr;
        m_awid      = lsu_awid;
        m_awlen     = lsu_awlen;
        m_awsize    = lsu_awsize;
        m_awburst   = lsu_awburst;
        lsu_awready = m_awready & ~aw_done_q;
        m_wvalid    = lsu_wvalid;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wlast     = lsu_wlast;
        lsu_wready  = m_wready;
        lsu_bvalid  = m_bvalid;
        lsu_bresp   = m_bresp;
        lsu_bid     = m_bid;
        m_bready    = lsu_bready;
        if (m_bvalid && m_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Address-accepted flags live for one grant and clear on release.
    ar_done_d = (state_d == IDLE) ? 1'b0 : (ar_done_q | (m_arvalid & m_arready));
    aw_done_d = (state_d == IDLE) ? 1'b0 : (aw_done_q | (m_awvalid & m_awready));
  end

endmodule

// File: tb/tb_ysyx_25030093_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter; a second instance covers round-robin mode.
module tb_ysyx_25030093_axi_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [3:0]  ifu_arid, ifu_rid;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic [1:0]  ifu_arburst, ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [3:0]  lsu_arid, lsu_rid;
  logic [7:0]  lsu_arlen;
  logic [2:0]  lsu_arsize;
  logic [1:0]  lsu_arburst, lsu_rresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0]  lsu_awid, lsu_wstrb, lsu_bid;
  logic [7:0]  lsu_awlen;
  logic [2:0]  lsu_awsize;
  logic [1:0]  lsu_awburst, lsu_bresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_awid, m_wstrb, m_bid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_bresp;

  ysyx_25030093_axi_arbiter #(.AW(32), .DW(32), .LSU_PRIORITY(1'b1)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
    .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
    .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
    .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
    .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid),
    .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
    .lsu_awready(lsu_awready), .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid), .lsu_bready(lsu_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rid(m_rid), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid),
    .m_bready(m_bready)
  );

  // Round-robin instance: both masters request forever, slave answers one beat per AR.
  logic        rr_rst_n = 1'b0;
  logic        rr_m_rvalid;
  logic        rr_ifu_arready, rr_ifu_rvalid, rr_ifu_rlast, rr_lsu_arready, rr_lsu_rvalid, rr_lsu_rlast;
  logic [31:0] rr_ifu_rdata, rr_lsu_rdata, rr_m_araddr, rr_m_awaddr, rr_m_wdata;
  logic [1:0]  rr_ifu_rresp, rr_lsu_rresp, rr_lsu_bresp, rr_m_arburst, rr_m_awburst;
  logic [3:0]  rr_ifu_rid, rr_lsu_rid, rr_lsu_bid, rr_m_arid, rr_m_awid, rr_m_wstrb;
  logic        rr_lsu_awready, rr_lsu_wready, rr_lsu_bvalid;
  logic        rr_m_arvalid, rr_m_rready, rr_m_awvalid, rr_m_wvalid, rr_m_wlast, rr_m_bready;
  logic [7:0]  rr_m_arlen, rr_m_awlen;
  logic [2:0]  rr_m_arsize, rr_m_awsize;

  ysyx_25030093_axi_arbiter #(.AW(32), .DW(32), .LSU_PRIORITY(1'b0)) dut_rr (
    .clock(clock), .reset(rr_rst_n),
    .ifu_arvalid(1'b1), .ifu_araddr(32'h0000_1000), .ifu_arid(4'd1),
    .ifu_arlen(8'd0), .ifu_arsize(3'd2), .ifu_arburst(2'd1),
    .ifu_arready(rr_ifu_arready), .ifu_rvalid(rr_ifu_rvalid), .ifu_rdata(rr_ifu_rdata),
    .ifu_rresp(rr_ifu_rresp), .ifu_rlast(rr_ifu_rlast), .ifu_rid(rr_ifu_rid), .ifu_rready(1'b1),
    .lsu_arvalid(1'b1), .lsu_araddr(32'h0000_2000), .lsu_arid(4'd2),
    .lsu_arlen(8'd0), .lsu_arsize(3'd2), .lsu_arburst(2'd1),
    .lsu_arready(rr_lsu_arready), .lsu_rvalid(rr_lsu_rvalid), .lsu_rdata(rr_lsu_rdata),
    .lsu_rresp(rr_lsu_rresp), .lsu_rlast(rr_lsu_rlast), .lsu_rid(rr_lsu_rid), .lsu_rready(1'b1),
    .lsu_awvalid(1'b0), .lsu_awaddr(32'h0), .lsu_awid(4'd0),
    .lsu_awlen(8'd0), .lsu_awsize(3'd0), .lsu_awburst(2'd0),
    .lsu_awready(rr_lsu_awready), .lsu_wvalid(1'b0), .lsu_wdata(32'h0),
    .lsu_wstrb(4'h0), .lsu_wlast(1'b0), .lsu_wready(rr_lsu_wready),
    .lsu_bvalid(rr_lsu_bvalid), .lsu_bresp(rr_lsu_bresp), .lsu_bid(rr_lsu_bid), .lsu_bready(1'b0),
    .m_arvalid(rr_m_arvalid), .m_araddr(rr_m_araddr), .m_arid(rr_m_arid), .m_arlen(rr_m_arlen),
    .m_arsize(rr_m_arsize), .m_arburst(rr_m_arburst), .m_arready(1'b1),
    .m_rvalid(rr_m_rvalid), .m_rdata(32'h0), .m_rresp(2'd0), .m_rlast(1'b1),
    .m_rid(4'd0), .m_rready(rr_m_rready),
    .m_awvalid(rr_m_awvalid), .m_awaddr(rr_m_awaddr), .m_awid(rr_m_awid), .m_awlen(rr_m_awlen),
    .m_awsize(rr_m_awsize), .m_awburst(rr_m_awburst), .m_awready(1'b0),
    .m_wvalid(rr_m_wvalid), .m_wdata(rr_m_wdata), .m_wstrb(rr_m_wstrb), .m_wlast(rr_m_wlast),
    .m_wready(1'b0), .m_bvalid(1'b0), .m_bresp(2'd0), .m_bid(4'd0),
    .m_bready(rr_m_bready)
  );

  always @(posedge clock or negedge rr_rst_n) begin
    if (!rr_rst_n)                      rr_m_rvalid <= 1'b0;
    else if (rr_m_arvalid)              rr_m_rvalid <= 1'b1;
    else if (rr_m_rvalid && rr_m_rready) rr_m_rvalid <= 1'b0;
  end

  bit grants[$];  // 1 = LSU won the AR handshake, 0 = IFU
  always @(posedge clock) begin
    if (rr_rst_n && rr_m_arvalid) grants.push_back(rr_lsu_arready);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    {ifu_arvalid, ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize, ifu_arburst, ifu_rready} = '0;
    {lsu_arvalid, lsu_araddr, lsu_arid, lsu_arlen, lsu_arsize, lsu_arburst, lsu_rready} = '0;
    {lsu_awvalid, lsu_awaddr, lsu_awid, lsu_awlen, lsu_awsize, lsu_awburst} = '0;
    {lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_wlast, lsu_bready} = '0;
    {m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid} = '0;
    {m_awready, m_wready, m_bvalid, m_bresp, m_bid} = '0;

    // Reset holds every handshake output low even with active inputs
    step(); step();
    ifu_arvalid = 1'b1; lsu_awvalid = 1'b1; m_rvalid = 1'b1; m_bvalid = 1'b1;
    m_arready = 1'b1; ifu_rready = 1'b1; lsu_bready = 1'b1;
    #1;
    chk("reset_outputs", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, ifu_arready,
        ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid}), 64'd0);
    step();
    lsu_awvalid = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0; lsu_bready = 1'b0;

    // Test 1: single IFU read
    reset = 1'b1;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_arid = 4'd3; ifu_arsize = 3'd2; ifu_arburst = 2'd1;
    #1;
    chk("t1_idle_no_fwd", 64'({m_arvalid, ifu_arready}), 64'd0);
    step();
    chk("t1_arvalid_fwd", 64'(m_arvalid), 64'd1);
    chk("t1_araddr", 64'(m_araddr), 64'h3000_0000);
    chk("t1_arid", 64'(m_arid), 64'd3);
    chk("t1_arready", 64'(ifu_arready), 64'd1);
    step();
    #1;
    chk("t1_ar_once_mask", 64'({m_arvalid, ifu_arready}), 64'd0);
    ifu_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rlast = 1'b1; m_rid = 4'd3;
    #1;
    chk("t1_rvalid", 64'(ifu_rvalid), 64'd1);
    chk("t1_rdata", 64'(ifu_rdata), 64'hDEAD_BEEF);
    chk("t1_rid", 64'(ifu_rid), 64'd3);
    chk("t1_rready", 64'(m_rready), 64'd1);
    step();
    #1;
    chk("t1_stray_r_idle", 64'({m_rready, ifu_rvalid}), 64'd0);
    m_rvalid = 1'b0;
    step();

    // Test 2: simultaneous reads, LSU wins
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_1000; ifu_arid = 4'd0;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_2000; lsu_arid = 4'd5;
    step();
    #1;
    chk("t2_lsu_first_addr", 64'(m_araddr), 64'h0000_2000);
    chk("t2_lsu_arid", 64'(m_arid), 64'd5);
    chk("t2_ready_pair", 64'({lsu_arready, ifu_arready}), 64'b10);
    step();
    lsu_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA; m_rlast = 1'b1; m_rid = 4'd5;
    lsu_rready = 1'b1; ifu_rready = 1'b0;
    #1;
    chk("t2_lsu_rdata", 64'(lsu_rdata), 64'h5555_AAAA);
    chk("t2_lsu_rid", 64'(lsu_rid), 64'd5);
    chk("t2_ifu_blocked", 64'({ifu_arready, ifu_rvalid, m_arvalid}), 64'd0);
    step();
    m_rvalid = 1'b0; lsu_rready = 1'b0;
    #1;
    chk("t2_gap_cycle", 64'({ifu_arready, m_arvalid}), 64'd0);
    step();
    #1;
    chk("t2_ifu_addr", 64'(m_araddr), 64'h0000_1000);
    chk("t2_ifu_arready", 64'(ifu_arready), 64'd1);
    step();
    ifu_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h1111_2222; m_rlast = 1'b1; m_rid = 4'd0; ifu_rready = 1'b1;
    #1;
    chk("t2_ifu_rdata", 64'(ifu_rdata), 64'h1111_2222);
    step();
    m_rvalid = 1'b0;

    // Test 3: LSU write, AW accepted three cycles before W, error response
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0004; lsu_awid = 4'd2; lsu_awsize = 3'd2; lsu_awburst = 2'd1;
    lsu_wvalid = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b1111; lsu_wlast = 1'b1;
    lsu_bready = 1'b1; m_awready = 1'b0; m_wready = 1'b0;
    #1;
    chk("t3_idle_no_aw", 64'({m_awvalid, lsu_awready, m_wvalid}), 64'd0);
    step();
    #1;
    chk("t3_awvalid", 64'(m_awvalid), 64'd1);
    chk("t3_awaddr", 64'(m_awaddr), 64'h8000_0004);
    chk("t3_awid", 64'(m_awid), 64'd2);
    chk("t3_w_payload", 64'({m_wvalid, m_wdata, m_wstrb, m_wlast}), 64'({1'b1, 32'h1234_5678, 4'hF, 1'b1}));
    chk("t3_no_ar", 64'(m_arvalid), 64'd0);
    chk("t3_awready_wait", 64'(lsu_awready), 64'd0);
    m_awready = 1'b1;
    #1;
    chk("t3_awready", 64'(lsu_awready), 64'd1);
    step();
    #1;
    chk("t3_aw_once_mask", 64'({m_awvalid, lsu_awready}), 64'd0);
    chk("t3_w_wait1", 64'({m_wvalid, lsu_wready}), 64'b10);
    step();
    #1;
    chk("t3_w_wait2", 64'({m_wvalid, lsu_wready}), 64'b10);
    step();
    m_wready = 1'b1;
    #1;
    chk("t3_wready", 64'(lsu_wready), 64'd1);
    chk("t3_wdata_late", 64'(m_wdata), 64'h1234_5678);
    step();
    lsu_wvalid = 1'b0; lsu_awvalid = 1'b0; m_wready = 1'b0; m_awready = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b10; m_bid = 4'd2;
    #1;
    chk("t3_bvalid", 64'(lsu_bvalid), 64'd1);
    chk("t3_bresp_err", 64'(lsu_bresp), 64'd2);
    chk("t3_bid", 64'(lsu_bid), 64'd2);
    chk("t3_bready", 64'(m_bready), 64'd1);
    chk("t3_no_ar_b", 64'({m_arvalid, m_rready}), 64'd0);
    step();
    m_bvalid = 1'b0;
    #1;
    chk("t3_released", 64'({m_bready, lsu_bvalid, m_awvalid}), 64'd0);

    // Test 4: IFU burst of four beats, pending LSU read served afterwards
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0100; ifu_arlen = 8'd3;
    step();
    #1;
    chk("t4_arlen", 64'(m_arlen), 64'd3);
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_2222;
    #1;
    chk("t4_lsu_wait", 64'(lsu_arready), 64'd0);
    step();
    ifu_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rdata = 32'hA0 + 32'(i); m_rlast = (i == 3); m_rid = 4'd0;
      #1;
      chk($sformatf("t4_beat%0d", i), 64'({ifu_rvalid, ifu_rlast, ifu_rdata}),
          64'({1'b1, (i == 3), 32'hA0 + 32'(i)}));
      chk($sformatf("t4_lsu_held%0d", i), 64'({lsu_arready, lsu_rvalid}), 64'd0);
      step();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("t4_gap_cycle", 64'({lsu_arready, m_arvalid}), 64'd0);
    step();
    #1;
    chk("t4_lsu_addr", 64'(m_araddr), 64'h0000_2222);
    chk("t4_lsu_arready", 64'(lsu_arready), 64'd1);
    step();
    lsu_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; lsu_rready = 1'b1;
    step();
    m_rvalid = 1'b0; lsu_rready = 1'b0;

    // Test 5: reset in the middle of a burst, then a fresh read
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0200; ifu_arlen = 8'd3;
    step();
    step();
    ifu_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b0;
    step();
    step();
    #1;
    chk("t5_beat3_live", 64'(ifu_rvalid), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_async_drop", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, ifu_arready,
        ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid}), 64'd0);
    step();
    reset = 1'b1; m_rvalid = 1'b0;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0300; ifu_arlen = 8'd0;
    step();
    #1;
    chk("t5_new_ar", 64'({m_arvalid, m_araddr}), 64'({1'b1, 32'h3000_0300}));
    step();
    ifu_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D; m_rlast = 1'b1;
    #1;
    chk("t5_new_rdata", 64'({ifu_rvalid, ifu_rdata}), 64'({1'b1, 32'hCAFE_F00D}));
    step();
    m_rvalid = 1'b0;

    // Test 6: round-robin alternation; last-served starts as IFU so LSU goes first
    rr_rst_n = 1'b1;
    for (int i = 0; i < 400 && grants.size() < 20; i++) step();
    chk("t6_grant_count", 64'(grants.size() >= 20), 64'd1);
    for (int i = 0; i < 20; i++) begin
      if (i < grants.size()) chk($sformatf("t6_grant%0d", i), 64'(grants[i]), 64'((i % 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
